alu_share_ctrl: RTL and testbench

Sequencer and two-way arbiter for the single shared ALU in the SoC datapath. Two requesters (port 0: execute stage, port 1: auxiliary unit such as a branch/address helper) submit operand/opcode triples over valid/ready handshakes. The block grants one per transaction with round-robin fairness, drives registered operands into the ALU, captures the ALU result and flag, and returns them on the granted requester's response channel. One transaction is in flight at a time; a 16-bit completed-operation counter is exposed for debug.

---
 rtl/alu_share_ctrl.sv | 80 ++++++++
 tb/tb_alu_share_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin two-port sequencer for the shared ALU
module alu_share_ctrl #(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [31:0]    req0_a,
   input  logic [31:0]    req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [31:0]    req1_a,
   input  logic [31:0]    req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           resp0_valid,
   input  logic           resp0_ready,
   output logic           resp1_valid,
   input  logic           resp1_ready,
   output logic [31:0]    resp_c,
   output logic           resp_f,
   output logic [31:0]    alu_a,
   output logic [31:0]    alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [31:0]    alu_c,
   input  logic           alu_f,
   output logic           busy,
   output logic [15:0]    ops_done
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, owner, grant1, accept, done;
   // arbitration, handshakes and next-state selection
   always_comb begin
      grant1 = req1_valid && (!req0_valid || !last_grant);
      req0_ready = !rst && state == IDLE && req0_valid && !grant1;
      req1_ready = !rst && state == IDLE && grant1;
      resp0_valid = !rst && state == RESP && !owner;
      resp1_valid = !rst && state == RESP && owner;
      accept = req0_ready || req1_ready;
      done = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
      busy = state != IDLE;
      state_nx = state;
      case (state)
         IDLE: state_nx = accept ? EXEC : IDLE;
         EXEC: state_nx = RESP;
         RESP: state_nx = done ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   // state, operand latch, result capture and completion counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last_grant <= 1'b1;
         owner <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
         alu_op <= '0;
         resp_c <= '0;
         resp_f <= 1'b0;
         ops_done <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            alu_a <= grant1 ? req1_a : req0_a;
            alu_b <= grant1 ? req1_b : req0_b;
            alu_op <= grant1 ? req1_op : req0_op;
            owner <= grant1;
            last_grant <= grant1;
         end
         if (state == EXEC) begin
            resp_c <= alu_c;
            resp_f <= alu_f;
         end
         ops_done <= ops_done + {15'd0, done};
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed table and corner-case checks for alu_share_ctrl
module tb_alu_share_ctrl;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd4, OP_SLT = 4'd5;
   logic clk = 0, rst = 1;
   logic req0_valid = 0, req1_valid = 0, resp0_ready = 0, resp1_ready = 0;
   logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp_f, alu_f, busy;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0] req0_op = 0, req1_op = 0, alu_op;
   logic [31:0] resp_c, alu_a, alu_b, alu_c;
   logic [15:0] ops_done;
   int total = 0, bad = 0;
   logic [15:0] exp_done = 0;
   typedef struct {
      bit p;
      logic [31:0] a, b;
      logic [3:0] op;
      logic [31:0] c;
      logic f;
   } vec_t;
   vec_t vecs[7];
   alu_share_ctrl #(.OPW(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_c(resp_c), .resp_f(resp_f), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_c(alu_c), .alu_f(alu_f), .busy(busy), .ops_done(ops_done)
   );
   always #5 clk = ~clk;
   // stand-in ALU: flag is signed less-than for SLT, zero result otherwise
   always_comb begin
      alu_c = alu_op == OP_ADD ? alu_a + alu_b :
              alu_op == OP_SUB ? alu_a - alu_b :
              alu_op == OP_AND ? alu_a & alu_b :
              alu_op == OP_XOR ? alu_a ^ alu_b :
              alu_op == OP_SLT ? {31'd0, $signed(alu_a) < $signed(alu_b)} : 32'd0;
      alu_f = alu_op == OP_SLT ? alu_c[0] : alu_c == 32'd0;
   end
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      exp_done = 0;
   endtask
   task automatic run_op(input vec_t v);
      @(negedge clk);
      req0_valid = !v.p; req1_valid = v.p;
      req0_a = v.a; req0_b = v.b; req0_op = v.op;
      req1_a = v.a; req1_b = v.b; req1_op = v.op;
      resp0_ready = 1; resp1_ready = 1;
      #1 chk("ready", {30'd0, req1_ready, req0_ready}, v.p ? 2 : 1);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      chk("exec_busy", {31'd0, busy}, 1);
      chk("alu_a", alu_a, v.a);
      chk("alu_op", {28'd0, alu_op}, {28'd0, v.op});
      @(negedge clk);
      chk("resp_valid", {30'd0, resp1_valid, resp0_valid}, v.p ? 2 : 1);
      chk("resp_c", resp_c, v.c);
      chk("resp_f", {31'd0, resp_f}, {31'd0, v.f});
      exp_done++;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("ops_done", {16'd0, ops_done}, {16'd0, exp_done});
   endtask
   initial begin
      vecs[0] = '{0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0};
      vecs[1] = '{1, 32'hF0, 32'h0F, OP_XOR, 32'hFF, 1'b0};
      vecs[2] = '{0, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1};
      vecs[3] = '{1, 32'd3, 32'd10, OP_SLT, 32'd1, 1'b1};
      vecs[4] = '{0, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0, 1'b1};
      vecs[5] = '{1, 32'hFF00FF00, 32'h0FF00FF0, OP_AND, 32'h0F000F00, 1'b0};
      vecs[6] = '{0, 32'h80000000, 32'd1, OP_SLT, 32'd1, 1'b1};
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ops", {16'd0, ops_done}, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 0);
      for (int i = 0; i < 7; i++) run_op(vecs[i]);
      do_reset();
      @(negedge clk);
      req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = OP_SUB;
      req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = OP_XOR;
      resp0_ready = 1; resp1_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("rr_grant", {30'd0, req1_ready, req0_ready}, i % 2 ? 2 : 1);
         @(negedge clk);
         @(negedge clk);
         chk("rr_valid", {30'd0, resp1_valid, resp0_valid}, i % 2 ? 2 : 1);
         chk("rr_c", resp_c, i % 2 ? 32'hFF : 32'd0);
         chk("rr_f", {31'd0, resp_f}, i % 2 ? 0 : 1);
         exp_done++;
         @(negedge clk);
      end
      chk("rr_ops", {16'd0, ops_done}, {16'd0, exp_done});
      req0_valid = 0; req1_valid = 0;
      do_reset();
      @(negedge clk);
      req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = OP_XOR;
      resp1_ready = 0; resp0_ready = 0;
      #1 chk("bp_acc", {31'd0, req1_ready}, 1);
      @(negedge clk);
      req1_valid = 0;
      req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = OP_ADD;
      chk("bp_exec_r0", {31'd0, req0_ready}, 0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {30'd0, resp1_valid, resp0_valid}, 2);
         chk("bp_c", resp_c, 32'hFF);
         chk("bp_r0", {31'd0, req0_ready}, 0);
         @(negedge clk);
      end
      resp1_ready = 1;
      exp_done++;
      @(negedge clk);
      resp1_ready = 0; resp0_ready = 1;
      chk("bp_ops", {16'd0, ops_done}, {16'd0, exp_done});
      #1 chk("bp_r0_idle", {31'd0, req0_ready}, 1);
      @(negedge clk);
      req0_valid = 0;
      @(negedge clk);
      chk("bp_r0_resp", {30'd0, resp1_valid, resp0_valid}, 1);
      chk("bp_r0_c", resp_c, 32'd12);
      exp_done++;
      @(negedge clk);
      do_reset();
      @(negedge clk);
      req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = OP_ADD; resp1_ready = 1;
      #1 chk("rx_acc", {31'd0, req1_ready}, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rx_busy", {31'd0, busy}, 0);
      chk("rx_alu_a", alu_a, 0);
      chk("rx_resp_c", resp_c, 0);
      chk("rx_ready", {30'd0, req1_ready, req0_ready}, 0);
      @(negedge clk);
      rst = 0;
      req1_valid = 0;
      exp_done = 0;
      for (int k = 0; k < 3; k++) begin
         chk("rx_no_resp", {30'd0, resp1_valid, resp0_valid}, 0);
         @(negedge clk);
      end
      req0_valid = 1; req1_valid = 1; req0_op = OP_ADD;
      #1 chk("rx_tie", {30'd0, req1_ready, req0_ready}, 1);
      req0_valid = 0; req1_valid = 0;
      chk("rx_ops", {16'd0, ops_done}, 0);
      @(negedge clk);
      force dut.ops_done = 16'hFFFE;
      #1 release dut.ops_done;
      exp_done = 16'hFFFE;
      for (int i = 0; i < 3; i++) run_op(vecs[i]);
      chk("wrap_final", {16'd0, ops_done}, 32'h0001);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
